sdram_init_seq: RTL and testbench

//  Parametrised SDRAM power-up initialisation sequencer, successor to sdram_init.

---
 rtl/sdram_pkg.sv | 40 ++++
 rtl/sdram_init_seq.sv | 180 ++++++++++++++++++
 tb/tb_sdram_init_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg
//   Shared definitions for the SDRAM initialisation sequencer:
//   - SDRAM command encodings {CS_n, RAS_n, CAS_n, WE_n}
//   - init FSM state enumeration
//   - mode_word(): builds the LOAD MODE REGISTER address word
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  typedef enum logic [2:0] {
    ST_WAIT_PU,
    ST_PRE,
    ST_W_RP,
    ST_AREF,
    ST_W_RFC,
    ST_MRS,
    ST_W_MRD,
    ST_DONE
  } init_state_t;

  // Mode register layout: A9=WB, A6:A4=CAS latency, A3=burst type,
  // A2:A0=burst length; every other bit is zero. The result is masked to
  // addr_w bits so the caller can slice it directly onto its address bus.
  function automatic logic [31:0] mode_word(input int         addr_w,
                                            input logic       wb,
                                            input logic [2:0] cas_lat,
                                            input logic       bt,
                                            input logic [2:0] bl_code);
    logic [31:0] w;
    w = {22'd0, wb, 2'b00, cas_lat, bt, bl_code};
    if (addr_w < 32) begin
      w = w & ((32'd1 << addr_w) - 32'd1);
    end
    return w;
  endfunction

endpackage

// File: rtl/sdram_init_seq.sv
// sdram_init_seq
//   SDRAM power-up initialisation sequencer. After reset it waits the
//   power-up time issuing NOPs, then issues PRECHARGE ALL, AREF_NUM AUTO
//   REFRESH commands and LOAD MODE REGISTER, and finally raises init_end.
//   A reinit_req pulse while init_end=1 re-runs the sequence without the
//   power-up wait. All outputs are registered.
// Ports
//   sys_clk    in   1       system clock, rising edge
//   sys_rst_n  in   1       synchronous active-low reset
//   reinit_req in   1       one-cycle request to re-run the sequence (only in DONE)
//   init_cmd   out  4       {CS_n,RAS_n,CAS_n,WE_n}
//   init_ba    out  BA_W    bank address (all ones except during LOAD_MR)
//   init_addr  out  ADDR_W  address (all ones except during LOAD_MR; A10=1 = precharge all)
//   init_end   out  1       high once the sequence has completed
module sdram_init_seq
  import sdram_pkg::*;
#(
  parameter int         CLK_FREQ_MHZ = 50,
  parameter int         T_POWERUP_US = 200,
  parameter int         T_RP_CYC     = 2,
  parameter int         T_RFC_CYC    = 7,
  parameter int         T_MRD_CYC    = 3,
  parameter int         AREF_NUM     = 8,
  parameter int         ADDR_W       = 13,
  parameter int         BA_W         = 2,
  parameter int         CAS_LAT      = 3,
  parameter int         BT           = 0,
  parameter logic [2:0] BL_CODE      = 3'b111,
  parameter int         WB           = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              reinit_req,
  output logic [3:0]        init_cmd,
  output logic [BA_W-1:0]   init_ba,
  output logic [ADDR_W-1:0] init_addr,
  output logic              init_end
);

  localparam int POWERUP_CYC = CLK_FREQ_MHZ * T_POWERUP_US;
  localparam int MAX_T       = (T_RP_CYC > T_RFC_CYC)
                               ? ((T_RP_CYC > T_MRD_CYC) ? T_RP_CYC : T_MRD_CYC)
                               : ((T_RFC_CYC > T_MRD_CYC) ? T_RFC_CYC : T_MRD_CYC);
  localparam int CNT_MAX     = (POWERUP_CYC > MAX_T) ? POWERUP_CYC : MAX_T;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);
  localparam int REF_W       = $clog2(AREF_NUM + 1);

  // A command occupies one cycle and its wait state fills the rest of the
  // spacing, so the wait counter is loaded with T-2 and the wait state is
  // skipped entirely when T=1.
  localparam logic [CNT_W-1:0] PU_LOAD  = CNT_W'(POWERUP_CYC);
  localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'((T_RP_CYC  > 1) ? T_RP_CYC  - 2 : 0);
  localparam logic [CNT_W-1:0] RFC_LOAD = CNT_W'((T_RFC_CYC > 1) ? T_RFC_CYC - 2 : 0);
  localparam logic [CNT_W-1:0] MRD_LOAD = CNT_W'((T_MRD_CYC > 1) ? T_MRD_CYC - 2 : 0);

  localparam logic [31:0]       MODE32    = mode_word(ADDR_W, 1'(WB), 3'(CAS_LAT), 1'(BT), BL_CODE);
  localparam logic [ADDR_W-1:0] MODE_ADDR = MODE32[ADDR_W-1:0];

  if (CLK_FREQ_MHZ < 1 || T_POWERUP_US < 1 || T_RP_CYC < 1 ||
      T_RFC_CYC < 1 || T_MRD_CYC < 1) begin : g_bad_timing
    $error("sdram_init_seq: clock frequency and T_* timing parameters must be >= 1");
  end
  if (AREF_NUM < 1) begin : g_bad_aref
    $error("sdram_init_seq: AREF_NUM must be >= 1");
  end
  if (ADDR_W < 11 || ADDR_W > 32) begin : g_bad_addr
    $error("sdram_init_seq: ADDR_W must be in 11..32");
  end

  init_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_dec;
  logic [REF_W-1:0]  r_aref, w_aref_nxt, w_aref_inc;
  logic [3:0]        r_cmd, w_cmd_nxt;
  logic [BA_W-1:0]   r_ba, w_ba_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_end, w_end_nxt;

  // Wait counter saturates at zero; the FSM leaves a wait state on zero.
  assign w_cnt_dec  = (r_cnt == '0) ? r_cnt : r_cnt - CNT_W'(1);
  assign w_aref_inc = r_aref + REF_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_aref_nxt  = r_aref;
    unique case (r_state)
      ST_WAIT_PU: begin
        if (r_cnt == '0) w_state_nxt = ST_PRE;
        else             w_cnt_nxt   = w_cnt_dec;
      end
      ST_PRE: begin
        w_aref_nxt = '0;
        if (T_RP_CYC == 1) begin
          w_state_nxt = ST_AREF;
        end else begin
          w_state_nxt = ST_W_RP;
          w_cnt_nxt   = RP_LOAD;
        end
      end
      ST_W_RP: begin
        if (r_cnt == '0) w_state_nxt = ST_AREF;
        else             w_cnt_nxt   = w_cnt_dec;
      end
      ST_AREF: begin
        w_aref_nxt = w_aref_inc;
        if (T_RFC_CYC == 1) begin
          w_state_nxt = (w_aref_inc == REF_W'(AREF_NUM)) ? ST_MRS : ST_AREF;
        end else begin
          w_state_nxt = ST_W_RFC;
          w_cnt_nxt   = RFC_LOAD;
        end
      end
      ST_W_RFC: begin
        if (r_cnt == '0) w_state_nxt = (r_aref == REF_W'(AREF_NUM)) ? ST_MRS : ST_AREF;
        else             w_cnt_nxt   = w_cnt_dec;
      end
      ST_MRS: begin
        if (T_MRD_CYC == 1) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_W_MRD;
          w_cnt_nxt   = MRD_LOAD;
        end
      end
      ST_W_MRD: begin
        if (r_cnt == '0) w_state_nxt = ST_DONE;
        else             w_cnt_nxt   = w_cnt_dec;
      end
      ST_DONE: begin
        if (reinit_req) w_state_nxt = ST_PRE;
      end
      default: w_state_nxt = ST_WAIT_PU;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up
  // with the state the FSM occupies during that cycle.
  always_comb begin
    w_cmd_nxt  = CMD_NOP;
    w_ba_nxt   = '1;
    w_addr_nxt = '1;
    w_end_nxt  = (w_state_nxt == ST_DONE);
    unique case (w_state_nxt)
      ST_PRE:  w_cmd_nxt = CMD_PRE;
      ST_AREF: w_cmd_nxt = CMD_AREF;
      ST_MRS: begin
        w_cmd_nxt  = CMD_LMR;
        w_ba_nxt   = '0;
        w_addr_nxt = MODE_ADDR;
      end
      default: w_cmd_nxt = CMD_NOP;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= ST_WAIT_PU;
      r_cnt   <= PU_LOAD;
      r_aref  <= '0;
      r_cmd   <= CMD_NOP;
      r_ba    <= '1;
      r_addr  <= '1;
      r_end   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_aref  <= w_aref_nxt;
      r_cmd   <= w_cmd_nxt;
      r_ba    <= w_ba_nxt;
      r_addr  <= w_addr_nxt;
      r_end   <= w_end_nxt;
    end
  end

  assign init_cmd  = r_cmd;
  assign init_ba   = r_ba;
  assign init_addr = r_addr;
  assign init_end  = r_end;

endmodule

// File: tb/tb_sdram_init_seq.sv
// tb_sdram_init_seq
//   Two sequencer instances share clock, reset and reinit_req: one with
//   default parameters, one with a short power-up and two refreshes.
//   A schedule model predicts each cycle's outputs into a scoreboard queue;
//   a table of hand-derived key events is checked against a log at the end.
module tb_sdram_init_seq;
  import sdram_pkg::*;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        fin;
  } outs_t;

  typedef struct {
    int    d;
    int    c;
    outs_t o;
  } sb_t;

  typedef struct {
    string name;
    int    d;
    int    c;
    outs_t o;
  } vec_t;

  localparam int LOG_N = 20480;
  localparam int LAST  = 20240;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_n;
  logic        rq;
  logic [3:0]  a_cmd,  b_cmd;
  logic [1:0]  a_ba,   b_ba;
  logic [12:0] a_addr, b_addr;
  logic        a_end,  b_end;

  sdram_init_seq dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .reinit_req(rq),
    .init_cmd(a_cmd), .init_ba(a_ba), .init_addr(a_addr), .init_end(a_end)
  );

  sdram_init_seq #(
    .T_POWERUP_US(1), .CAS_LAT(2), .BL_CODE(3'b010), .AREF_NUM(2)
  ) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .reinit_req(rq),
    .init_cmd(b_cmd), .init_ba(b_ba), .init_addr(b_addr), .init_end(b_end)
  );

  // Schedule model parameters per instance.
  int          PU   [0:1] = '{10000, 50};
  int          TRP  [0:1] = '{2, 2};
  int          TRFC [0:1] = '{7, 7};
  int          TMRD [0:1] = '{3, 3};
  int          NREF [0:1] = '{8, 2};
  logic [12:0] MODE [0:1] = '{13'h0037, 13'h0022};

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = -4;
  logic in_rst   [0:1] = '{1'b1, 1'b1};
  int   pre_at   [0:1] = '{1 << 30, 1 << 30};
  logic prev_end [0:1] = '{1'b0, 1'b0};
  logic [3:0] prev_cmd [0:1] = '{CMD_NOP, CMD_NOP};

  sb_t   sbq [$];
  vec_t  vt  [$];
  outs_t lg  [0:1][0:LOG_N-1];

  function automatic outs_t idle_outs();
    outs_t o;
    o.cmd = CMD_NOP; o.ba = 2'b11; o.addr = 13'h1fff; o.fin = 1'b0;
    return o;
  endfunction

  // off = cycles since the PRECHARGE of the current sequence.
  function automatic outs_t sched(input int d, input int off);
    outs_t o;
    int    lmr;
    o   = idle_outs();
    lmr = TRP[d] + NREF[d] * TRFC[d];
    if (off < 0) return o;
    if (off == 0) begin
      o.cmd = CMD_PRE;
    end else if (off >= TRP[d] && off < lmr && ((off - TRP[d]) % TRFC[d]) == 0) begin
      o.cmd = CMD_AREF;
    end else if (off == lmr) begin
      o.cmd = CMD_LMR; o.ba = 2'b00; o.addr = MODE[d];
    end
    o.fin = (off >= lmr + TMRD[d]);
    return o;
  endfunction

  task automatic predict(input int d, input int c, input logic rv, input logic qv);
    outs_t o;
    sb_t   e;
    o = idle_outs();
    if (!rv) begin
      in_rst[d] = 1'b1;
    end else if (in_rst[d]) begin
      in_rst[d] = 1'b0;
      pre_at[d] = c + PU[d];
    end else begin
      if (qv && prev_end[d]) pre_at[d] = c;
      o = sched(d, c - pre_at[d]);
    end
    prev_end[d] = o.fin;
    e.d = d; e.c = c; e.o = o;
    sbq.push_back(e);
  endtask

  function automatic outs_t actual(input int d);
    outs_t o;
    if (d == 0) begin
      o.cmd = a_cmd; o.ba = a_ba; o.addr = a_addr; o.fin = a_end;
    end else begin
      o.cmd = b_cmd; o.ba = b_ba; o.addr = b_addr; o.fin = b_end;
    end
    return o;
  endfunction

  task automatic report(input string nm, input int c, input outs_t act, input outs_t exp);
    $display("FAIL %s cyc=%0d actual cmd=%h ba=%h addr=%h end=%b required cmd=%h ba=%h addr=%h end=%b",
             nm, c, act.cmd, act.ba, act.addr, act.fin, exp.cmd, exp.ba, exp.addr, exp.fin);
  endtask

  task automatic step(input logic rv, input logic qv);
    sb_t   e;
    outs_t act;
    rst_n = rv;
    rq    = qv;
    @(posedge clk);
    cyc++;
    predict(0, cyc, rv, qv);
    predict(1, cyc, rv, qv);
    @(negedge clk);
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      act = actual(e.d);
      if (e.c >= 0 && e.c < LOG_N) lg[e.d][e.c] = act;
      checks++;
      if (act !== e.o) begin
        failures++;
        report(e.d == 0 ? "cycle_a" : "cycle_b", e.c, act, e.o);
      end
      checks++;
      if (!(act.cmd inside {CMD_NOP, CMD_PRE, CMD_AREF, CMD_LMR}) ||
          (act.cmd != CMD_NOP && prev_cmd[e.d] != CMD_NOP)) begin
        failures++;
        $display("FAIL cmd_legal_%0d cyc=%0d actual cmd=%h prev=%h required legal non-adjacent",
                 e.d, e.c, act.cmd, prev_cmd[e.d]);
      end
      prev_cmd[e.d] = act.cmd;
    end
  endtask

  task automatic add(input string nm, input int d, input int c, input logic [3:0] cmd,
                     input logic [1:0] ba, input logic [12:0] addr, input logic fin);
    vec_t v;
    v.name = nm; v.d = d; v.c = c;
    v.o.cmd = cmd; v.o.ba = ba; v.o.addr = addr; v.o.fin = fin;
    vt.push_back(v);
  endtask

  initial begin
    // Key events derived by hand from the timing rules.
    add("a_first",     0,     0, CMD_NOP,  2'b11, 13'h1fff, 1'b0);
    add("a_pu_last",   0,  9999, CMD_NOP,  2'b11, 13'h1fff, 1'b0);
    add("a_pre",       0, 10000, CMD_PRE,  2'b11, 13'h1fff, 1'b0);
    add("a_after_pre", 0, 10001, CMD_NOP,  2'b11, 13'h1fff, 1'b0);
    add("a_aref0",     0, 10002, CMD_AREF, 2'b11, 13'h1fff, 1'b0);
    add("a_aref7",     0, 10051, CMD_AREF, 2'b11, 13'h1fff, 1'b0);
    add("a_lmr",       0, 10058, CMD_LMR,  2'b00, 13'h0037, 1'b0);
    add("a_pre_end",   0, 10060, CMD_NOP,  2'b11, 13'h1fff, 1'b0);
    add("a_end",       0, 10061, CMD_NOP,  2'b11, 13'h1fff, 1'b1);
    add("a_re_pre",    0, 10066, CMD_PRE,  2'b11, 13'h1fff, 1'b0);
    add("a_re_aref0",  0, 10068, CMD_AREF, 2'b11, 13'h1fff, 1'b0);
    add("a_re_lmr",    0, 10124, CMD_LMR,  2'b00, 13'h0037, 1'b0);
    add("a_re_end",    0, 10127, CMD_NOP,  2'b11, 13'h1fff, 1'b1);
    add("a_in_reset",  0, 10162, CMD_NOP,  2'b11, 13'h1fff, 1'b0);
    add("a_rst_pu",    0, 20164, CMD_NOP,  2'b11, 13'h1fff, 1'b0);
    add("a_rst_pre",   0, 20165, CMD_PRE,  2'b11, 13'h1fff, 1'b0);
    add("a_rst_end",   0, 20226, CMD_NOP,  2'b11, 13'h1fff, 1'b1);
    add("b_pre",       1,    50, CMD_PRE,  2'b11, 13'h1fff, 1'b0);
    add("b_aref0",     1,    52, CMD_AREF, 2'b11, 13'h1fff, 1'b0);
    add("b_aref1",     1,    59, CMD_AREF, 2'b11, 13'h1fff, 1'b0);
    add("b_lmr",       1,    66, CMD_LMR,  2'b00, 13'h0022, 1'b0);
    add("b_pre_end",   1,    68, CMD_NOP,  2'b11, 13'h1fff, 1'b0);
    add("b_end",       1,    69, CMD_NOP,  2'b11, 13'h1fff, 1'b1);

    rst_n = 1'b0;
    rq    = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    // Three checked cycles in reset, then release at 200 ns.
    repeat (3) step(1'b0, 1'b0);
    // reinit pulses: 500 (A in WAIT_PU), 10005 (A in W_RFC),
    // 10066 (A done + 5), 10132 (start another sequence); reset over A's AREF #4.
    for (int c = 0; c <= LAST; c++) begin
      step(!(c >= 10162 && c <= 10164),
           (c == 500 || c == 10005 || c == 10066 || c == 10132));
    end
    rq = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      checks++;
      if (lg[vt[i].d][vt[i].c] !== vt[i].o) begin
        failures++;
        report(vt[i].name, vt[i].c, lg[vt[i].d][vt[i].c], vt[i].o);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
